// File: rtl/display_writer.sv
// -----------------------------------------------------------------------------
// display_writer
//
// Purpose:
//   On each refresh request, starts one dual2ascii conversion and waits for its
//   result. It then writes the six result digits to a character LCD as a fixed
//   sequence of 8 writes:
//     line-1 address, tens, ones, line-2 address, thousands, hundreds, tens, ones.
//   A conversion that does not answer within TIMEOUT cycles is abandoned
//   without touching the LCD, and timeout_err pulses for one cycle. Refresh
//   requests that arrive while a refresh is in progress are folded into a
//   single pending request, which is served as soon as the block is idle again.
//
// Parameters:
//   CMD_LINE1    LCD set-address command for the first digit of the upper line
//   CMD_LINE2    LCD set-address command for the first digit of the lower line
//   TIMEOUT      cycles to wait for valid_in before abandoning the refresh
//
// Ports:
//   clock        system clock; all state changes on its rising edge
//   reset        asynchronous, active-low reset
//   refresh_tick one-cycle refresh request
//   valid_in     conversion-done pulse from dual2ascii
//   upper10/01   ASCII upper-line digits, tens then ones
//   lower1000..0001  ASCII lower-line digits, most significant first
//   lcd_ready    LCD controller can accept a write this cycle
//   conv_start   one-cycle start pulse to dual2ascii
//   lcd_data     command or character byte (0 when no write is made)
//   lcd_rs       0 = command, 1 = character (0 when no write is made)
//   lcd_we       write strobe; one write per cycle it is high
//   busy         high whenever the FSM is not idle
//   timeout_err  one-cycle pulse when a conversion times out
// -----------------------------------------------------------------------------
module display_writer #(
    parameter logic [7:0] CMD_LINE1 = 8'h80,
    parameter logic [7:0] CMD_LINE2 = 8'hC0,
    parameter int         TIMEOUT   = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       valid_in,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    input  logic       lcd_ready,
    output logic       conv_start,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_we,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        WAIT_CONV,
        WR_CMD1,
        WR_U10,
        WR_U01,
        WR_CMD2,
        WR_L1000,
        WR_L0100,
        WR_L0010,
        WR_L0001
    } state_t;

    // The wait counter is 8 bits and saturates, so a TIMEOUT beyond 256
    // cannot be represented; it is clamped to the longest count available.
    localparam logic [7:0] TO_LAST = (TIMEOUT >= 256) ? 8'hFF : 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic       r_pending;

    logic [7:0] r_u10;
    logic [7:0] r_u01;
    logic [7:0] r_l1000;
    logic [7:0] r_l0100;
    logic [7:0] r_l0010;
    logic [7:0] r_l0001;

    logic       w_wr_active;
    logic [7:0] w_wr_data;
    logic       w_wr_rs;
    logic       w_to_hit;
    logic       w_start_req;

    // r_cnt holds the number of WAIT_CONV cycles already spent, so the
    // TIMEOUT-th waiting cycle is the one that sees r_cnt == TIMEOUT-1.
    assign w_to_hit    = (r_cnt >= TO_LAST);
    assign w_start_req = (r_state == IDLE) && (refresh_tick || r_pending);
    assign busy        = (r_state != IDLE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-state outputs
    always_comb begin
        w_next      = r_state;
        conv_start  = 1'b0;
        timeout_err = 1'b0;
        w_wr_active = 1'b0;
        w_wr_data   = 8'h00;
        w_wr_rs     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_start_req) w_next = REQ;
            end
            REQ: begin
                conv_start = 1'b1;
                w_next     = WAIT_CONV;
            end
            WAIT_CONV: begin
                // A result arriving on the last allowed cycle still counts.
                if (valid_in) begin
                    w_next = WR_CMD1;
                end else if (w_to_hit) begin
                    timeout_err = 1'b1;
                    w_next      = IDLE;
                end
            end
            WR_CMD1: begin
                w_wr_active = 1'b1;
                w_wr_data   = CMD_LINE1;
                if (lcd_ready) w_next = WR_U10;
            end
            WR_U10: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_u10;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = WR_U01;
            end
            WR_U01: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_u01;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = WR_CMD2;
            end
            WR_CMD2: begin
                w_wr_active = 1'b1;
                w_wr_data   = CMD_LINE2;
                if (lcd_ready) w_next = WR_L1000;
            end
            WR_L1000: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_l1000;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = WR_L0100;
            end
            WR_L0100: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_l0100;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = WR_L0010;
            end
            WR_L0010: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_l0010;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = WR_L0001;
            end
            WR_L0001: begin
                w_wr_active = 1'b1;
                w_wr_data   = r_l0001;
                w_wr_rs     = 1'b1;
                if (lcd_ready) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // The LCD bus is forced to zero whenever no write is being made, so a
    // stalled state never presents stale data on the pins.
    assign lcd_we   = w_wr_active & lcd_ready;
    assign lcd_data = lcd_we ? w_wr_data : 8'h00;
    assign lcd_rs   = lcd_we & w_wr_rs;

    // Conversion wait counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'h00;
        end else if (r_state == REQ) begin
            r_cnt <= 8'h00;
        end else if ((r_state == WAIT_CONV) && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'h01;
        end
    end

    // One-deep pending request. Any tick seen while not idle, including one on
    // the final write cycle, is remembered; it is consumed when REQ is entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pending <= 1'b0;
        end else if (w_start_req) begin
            r_pending <= 1'b0;
        end else if (refresh_tick && (r_state != IDLE)) begin
            r_pending <= 1'b1;
        end
    end

    // Digit capture: only the valid_in seen in WAIT_CONV loads the registers,
    // so later input changes cannot disturb a sequence already under way.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_u10   <= 8'h00;
            r_u01   <= 8'h00;
            r_l1000 <= 8'h00;
            r_l0100 <= 8'h00;
            r_l0010 <= 8'h00;
            r_l0001 <= 8'h00;
        end else if ((r_state == WAIT_CONV) && valid_in) begin
            r_u10   <= upper10;
            r_u01   <= upper01;
            r_l1000 <= lower1000;
            r_l0100 <= lower0100;
            r_l0010 <= lower0010;
            r_l0001 <= lower0001;
        end
    end

endmodule
